// File: rtl/alu_mb_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_mb_seq
// Description : Multi-byte arithmetic/shift sequencer. Takes one command from
//               the CPU microcode and runs it over NBYTES bytes on the shared
//               8-bit registered ALU, one byte per cycle. The ALU carry-out of
//               each byte feeds the carry-in of the next byte. The result is
//               assembled into an NBYTES-wide word with 6502-style C/V/N/Z
//               flags.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   NBYTES     operand width in bytes (1..8); W = 8*NBYTES
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   rdy        global ready; 0 freezes the sequencer and the ALU
//   start      request, accepted only in IDLE with rdy=1
//   cmd        000 ADD, 001 SUB, 010 ASL, 011 ROL,
//              100 LSR, 101 ROR, 110 XOR, 111 AND
//   bcd        decimal mode (ADD/SUB only)
//   cin        carry in
//   a_i, b_i   operands (W bits), latched on accept
//   busy       high from accept+1 through the final capture cycle
//   done       one-cycle pulse, result and flags valid
//   res_o      result, held until the next command completes
//   c_o/v_o/n_o/z_o  final flags
//   alu_*      ALU control/operand outputs; alu_out/alu_co/alu_v/alu_n are the
//              ALU's registered results for the byte issued last cycle
// ============================================================================
module alu_mb_seq #(
  parameter int NBYTES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rdy,
  input  logic                  start,
  input  logic [2:0]            cmd,
  input  logic                  bcd,
  input  logic                  cin,
  input  logic [8*NBYTES-1:0]   a_i,
  input  logic [8*NBYTES-1:0]   b_i,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   res_o,
  output logic                  c_o,
  output logic                  v_o,
  output logic                  n_o,
  output logic                  z_o,
  output logic [3:0]            alu_op,
  output logic                  alu_right,
  output logic [7:0]            alu_ai,
  output logic [7:0]            alu_bi,
  output logic                  alu_ci,
  output logic                  alu_bcd,
  output logic                  alu_rdy,
  input  logic [7:0]            alu_out,
  input  logic                  alu_co,
  input  logic                  alu_v,
  input  logic                  alu_n
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [2:0] CMD_ADD = 3'b000;
  localparam logic [2:0] CMD_SUB = 3'b001;
  localparam logic [2:0] CMD_ASL = 3'b010;
  localparam logic [2:0] CMD_ROL = 3'b011;
  localparam logic [2:0] CMD_LSR = 3'b100;
  localparam logic [2:0] CMD_ROR = 3'b101;
  localparam logic [2:0] CMD_XOR = 3'b110;
  localparam logic [2:0] CMD_AND = 3'b111;

  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0111;
  localparam logic [3:0] OP_SHL   = 4'b1011;
  localparam logic [3:0] OP_SHR   = 4'b1111;
  localparam logic [3:0] OP_XOR   = 4'b1110;
  localparam logic [3:0] OP_AND   = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAST = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Command decode helpers
  // --------------------------------------------------------------------------
  function automatic logic is_arith(input logic [2:0] c);
    return (c == CMD_ADD) || (c == CMD_SUB);
  endfunction

  function automatic logic is_logic(input logic [2:0] c);
    return (c == CMD_XOR) || (c == CMD_AND);
  endfunction

  function automatic logic is_right(input logic [2:0] c);
    return (c == CMD_LSR) || (c == CMD_ROR);
  endfunction

  function automatic logic is_shift(input logic [2:0] c);
    return !is_arith(c) && !is_logic(c);
  endfunction

  function automatic logic [3:0] op_of(input logic [2:0] c);
    logic [3:0] op;
    case (c)
      CMD_ADD:          op = OP_ADD;
      CMD_SUB:          op = OP_SUB;
      CMD_ASL, CMD_ROL: op = OP_SHL;
      CMD_LSR, CMD_ROR: op = OP_SHR;
      CMD_XOR:          op = OP_XOR;
      default:          op = OP_AND;
    endcase
    return op;
  endfunction

  // ASL/LSR shift in a zero; every other command starts from the caller's
  // carry (for the logic ops the ALU ignores it).
  function automatic logic first_ci(input logic [2:0] c, input logic ci);
    return ((c == CMD_ASL) || (c == CMD_LSR)) ? 1'b0 : ci;
  endfunction

  // Step k of the sequence touches byte k, except right shifts which must
  // walk from the MSB down so the shifted-out bit carries into the next
  // lower byte.
  function automatic logic [IW-1:0] byte_pos(input logic [2:0] c,
                                             input logic [IW-1:0] k);
    return is_right(c) ? (IW'(NBYTES - 1) - k) : k;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t                  state_q,     state_d;
  logic [IW-1:0]           idx_q,       idx_d;
  logic [NBYTES-1:0][7:0]  a_q,         a_d;
  logic [NBYTES-1:0][7:0]  b_q,         b_d;
  logic [NBYTES-1:0][7:0]  acc_q,       acc_d;
  logic [NBYTES-1:0][7:0]  res_q,       res_d;
  logic [2:0]              cmd_q,       cmd_d;
  logic                    cin_q,       cin_d;
  logic                    done_q,      done_d;
  logic                    c_q,         c_d;
  logic                    v_q,         v_d;
  logic                    n_q,         n_d;
  logic                    z_q,         z_d;
  logic [3:0]              alu_op_q,    alu_op_d;
  logic                    alu_right_q, alu_right_d;
  logic [7:0]              alu_ai_q,    alu_ai_d;
  logic [7:0]              alu_bi_q,    alu_bi_d;
  logic                    alu_ci0_q,   alu_ci0_d;
  logic                    alu_bcd_q,   alu_bcd_d;

  logic [IW-1:0]           nxt_idx;
  logic [IW-1:0]           nxt_pos;
  logic [IW-1:0]           a0_pos;

  // The N flag is taken from the assembled word's MSB, which is not the last
  // byte processed for right shifts, so the ALU's N output is not consulted.
  logic unused_alu_n;
  assign unused_alu_n = alu_n;

  assign nxt_idx = idx_q + IW'(1);
  assign nxt_pos = byte_pos(cmd_q, nxt_idx);
  assign a0_pos  = byte_pos(cmd, '0);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    res_d       = res_q;
    cmd_d       = cmd_q;
    cin_d       = cin_q;
    done_d      = 1'b0;
    c_d         = c_q;
    v_d         = v_q;
    n_d         = n_q;
    z_d         = z_q;
    alu_op_d    = alu_op_q;
    alu_right_d = alu_right_q;
    alu_ai_d    = alu_ai_q;
    alu_bi_d    = alu_bi_q;
    alu_ci0_d   = alu_ci0_q;
    alu_bcd_d   = alu_bcd_q;

    case (state_q)
      ST_IDLE: begin
        if (start && rdy) begin
          a_d         = a_i;
          b_d         = b_i;
          cmd_d       = cmd;
          cin_d       = cin;
          idx_d       = '0;
          acc_d       = '0;
          // First byte goes onto the ALU bus straight from the accept cycle.
          alu_op_d    = op_of(cmd);
          alu_right_d = is_right(cmd);
          alu_bcd_d   = bcd && is_arith(cmd);
          alu_ai_d    = a_d[a0_pos];
          alu_bi_d    = is_shift(cmd) ? 8'h00 : b_d[a0_pos];
          alu_ci0_d   = first_ci(cmd, cin);
          state_d     = ST_RUN;
        end
      end

      ST_RUN: begin
        if (rdy) begin
          // alu_out now holds the byte issued in the previous RUN step.
          if (idx_q != '0) begin
            acc_d[byte_pos(cmd_q, idx_q - IW'(1))] = alu_out;
          end
          if (idx_q == IW'(NBYTES - 1)) begin
            state_d = ST_LAST;
          end else begin
            idx_d    = nxt_idx;
            alu_ai_d = a_q[nxt_pos];
            alu_bi_d = is_shift(cmd_q) ? 8'h00 : b_q[nxt_pos];
          end
        end
      end

      ST_LAST: begin
        if (rdy) begin
          acc_d[byte_pos(cmd_q, idx_q)] = alu_out;
          res_d   = acc_d;
          c_d     = is_logic(cmd_q) ? cin_q : alu_co;
          v_d     = alu_v;
          n_d     = acc_d[NBYTES-1][7];
          z_d     = (acc_d == '0);
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      res_q       <= '0;
      cmd_q       <= '0;
      cin_q       <= 1'b0;
      done_q      <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      n_q         <= 1'b0;
      z_q         <= 1'b0;
      alu_op_q    <= '0;
      alu_right_q <= 1'b0;
      alu_ai_q    <= '0;
      alu_bi_q    <= '0;
      alu_ci0_q   <= 1'b0;
      alu_bcd_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      cmd_q       <= cmd_d;
      cin_q       <= cin_d;
      done_q      <= done_d;
      c_q         <= c_d;
      v_q         <= v_d;
      n_q         <= n_d;
      z_q         <= z_d;
      alu_op_q    <= alu_op_d;
      alu_right_q <= alu_right_d;
      alu_ai_q    <= alu_ai_d;
      alu_bi_q    <= alu_bi_d;
      alu_ci0_q   <= alu_ci0_d;
      alu_bcd_q   <= alu_bcd_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign res_o     = res_q;
  assign c_o       = c_q;
  assign v_o       = v_q;
  assign n_o       = n_q;
  assign z_o       = z_q;
  assign alu_op    = alu_op_q;
  assign alu_right = alu_right_q;
  assign alu_ai    = alu_ai_q;
  assign alu_bi    = alu_bi_q;
  assign alu_bcd   = alu_bcd_q;

  // The ALU's carry for byte k-1 only becomes visible in the cycle byte k is
  // issued, so the chained carry cannot be registered ahead of time.
  assign alu_ci    = ((state_q == ST_RUN) && (idx_q != '0)) ? alu_co : alu_ci0_q;

  // Clock the ALU only while a byte is actually being issued.
  assign alu_rdy   = rdy && (state_q == ST_RUN);

endmodule
`default_nettype wire
